// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, total-period derivation and the coordinate type.
package vga_pkg;

   localparam int COORD_W = 10;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   typedef logic [COORD_W-1:0] coord_t;

   function automatic int timing_total(input int active, input int fp,
                                       input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int H_TOTAL_DEF = timing_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
   localparam int V_TOTAL_DEF = timing_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_pix_tick.sv
// Divide-by-2 pixel enable: high on every second clk, first high cycle
// ends at the second clk after reset release.
module vga_pix_tick (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tick <= 1'b0;
      else        tick <= ~tick;
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync/timing generator with registered, mutually aligned outputs.
// Optional feature: define VGA_CHECKER_EN for a 32x32 checkerboard on color_out.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic [COORD_W-1:0] pixel_x,
   output logic [COORD_W-1:0] pixel_y,
   output logic               color_out
);

   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
   localparam coord_t H_ACT      = coord_t'(H_ACTIVE);
   localparam coord_t V_ACT      = coord_t'(V_ACTIVE);
   localparam coord_t HS_START   = coord_t'(H_ACTIVE + H_FP);
   localparam coord_t HS_END     = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam coord_t VS_START   = coord_t'(V_ACTIVE + V_FP);
   localparam coord_t VS_END     = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic   tick;
   coord_t h_p0;
   coord_t v_p0;
   logic   hsync_p0;
   logic   vsync_p0;
   logic   video_p0;
   logic   color_p0;

   vga_pix_tick u_pix_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Stage p0: raster counters, advanced only on pixel ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_p0 <= '0;
         v_p0 <= '0;
      end else if (tick) begin
         if (h_p0 == H_LAST) begin
            h_p0 <= '0;
            v_p0 <= (v_p0 == V_LAST) ? '0 : v_p0 + coord_t'(1);
         end else begin
            h_p0 <= h_p0 + coord_t'(1);
         end
      end
   end

   always_comb begin
      hsync_p0 = 1'b1;
      vsync_p0 = 1'b1;
      video_p0 = 1'b0;
      color_p0 = 1'b0;
      if (h_p0 >= HS_START && h_p0 <= HS_END) hsync_p0 = 1'b0;
      if (v_p0 >= VS_START && v_p0 <= VS_END) vsync_p0 = 1'b0;
      video_p0 = (h_p0 < H_ACT) && (v_p0 < V_ACT);
`ifdef VGA_CHECKER_EN
      color_p0 = video_p0 & ~(h_p0[5] ^ v_p0[5]);
`else
      color_p0 = video_p0;
`endif
   end

   // Stage p1: every output registered from the same (h,v) pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync     <= 1'b1;
         vsync     <= 1'b1;
         video_on  <= 1'b0;
         color_out <= 1'b0;
         pixel_x   <= '0;
         pixel_y   <= '0;
      end else begin
         hsync     <= hsync_p0;
         vsync     <= vsync_p0;
         video_on  <= video_p0;
         color_out <= color_p0;
         pixel_x   <= h_p0;
         pixel_y   <= v_p0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using reduced timing and a closed-form raster model.
module tb_vga_sync_gen;

   localparam int HA = 40, HFP = 4, HSY = 6, HBP = 6;
   localparam int VA = 36, VFP = 3, VSY = 2, VBP = 4;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int F  = 2 * HT * VT;
   localparam logic [23:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       hsync, vsync, video_on, color_out;
   logic [9:0] pixel_x, pixel_y;

   int checks = 0;
   int errors = 0;
   int k = 0;

   vga_sync_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync),
      .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .color_out(color_out)
   );

   always #5 clk = ~clk;

   // Outputs after clk k reflect the raster position reached after (k-1)/2 pixel ticks.
   function automatic logic [23:0] model(input int kk);
      int t, pos, h, v;
      logic hs, vs, vid, col;
      if (kk == 0) return RST_VEC;
      t   = (kk - 1) / 2;
      pos = t % (HT * VT);
      h   = pos % HT;
      v   = pos / HT;
      hs  = !(h >= HA + HFP && h < HA + HFP + HSY);
      vs  = !(v >= VA + VFP && v < VA + VFP + VSY);
      vid = (h < HA) && (v < VA);
`ifdef VGA_CHECKER_EN
      col = vid && (((h / 32) % 2) == ((v / 32) % 2));
`else
      col = vid;
`endif
      return {hs, vs, vid, col, 10'(h), 10'(v)};
   endfunction

   function automatic logic [23:0] outs();
      return {hsync, vsync, video_on, color_out, pixel_x, pixel_y};
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst_n) k++;
      @(negedge clk);
   endtask

   task automatic goto_pixel(input int x, input int y, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < F + 8; i++) begin
         if (pixel_x == 10'(x) && pixel_y == 10'(y)) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      k = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (outs() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold got=%h expected=%h", outs(), RST_VEC);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_line();
      int first_fall = -1, second_fall = -1, low = 0;
      logic prev = 1'b1;
      for (int i = 0; i < 6 * HT; i++) begin
         step();
         checks++;
         if (outs() !== model(k)) begin
            errors++;
            $display("FAIL line_cycle k=%0d got=%h expected=%h", k, outs(), model(k));
         end
         if (prev && !hsync) begin
            if (first_fall < 0) first_fall = k;
            else if (second_fall < 0) second_fall = k;
         end
         if (k <= 2 * HT && !hsync) low++;
         prev = hsync;
      end
      checks++;
      if (first_fall != 2 * (HA + HFP) + 1) begin
         errors++;
         $display("FAIL hsync_first_fall got=%0d expected=%0d", first_fall, 2 * (HA + HFP) + 1);
      end
      checks++;
      if (low != 2 * HSY) begin
         errors++;
         $display("FAIL hsync_low_clks got=%0d expected=%0d", low, 2 * HSY);
      end
      checks++;
      if (second_fall - first_fall != 2 * HT) begin
         errors++;
         $display("FAIL line_period got=%0d expected=%0d", second_fall - first_fall, 2 * HT);
      end
   endtask

   task automatic test_frame();
      int vcnt[VT];
      int vlow = 0, fall1 = -1, fall2 = -1, line;
      logic prev = vsync;
      foreach (vcnt[i]) vcnt[i] = 0;
      while (k < 2 * F) begin
         step();
         checks++;
         if (outs() !== model(k)) begin
            errors++;
            $display("FAIL frame_cycle k=%0d got=%h expected=%h", k, outs(), model(k));
         end
         if (prev && !vsync) begin
            if (fall1 < 0) fall1 = k;
            else if (fall2 < 0) fall2 = k;
         end
         prev = vsync;
         if (k > F) begin
            line = ((k - 1) / 2 - F / 2) / HT;
            if (!vsync) vlow++;
            if (video_on && line < VT) vcnt[line]++;
         end
      end
      checks++;
      if (fall1 != 2 * (VA + VFP) * HT + 1) begin
         errors++;
         $display("FAIL vsync_first_fall got=%0d expected=%0d", fall1, 2 * (VA + VFP) * HT + 1);
      end
      checks++;
      if (vlow != 2 * VSY * HT) begin
         errors++;
         $display("FAIL vsync_low_clks got=%0d expected=%0d", vlow, 2 * VSY * HT);
      end
      checks++;
      if (fall2 - fall1 != F) begin
         errors++;
         $display("FAIL frame_period got=%0d expected=%0d", fall2 - fall1, F);
      end
      for (int i = 0; i < VT; i++) begin
         checks++;
         if (vcnt[i] != ((i < VA) ? 2 * HA : 0)) begin
            errors++;
            $display("FAIL video_on_line%0d got=%0d expected=%0d", i, vcnt[i], (i < VA) ? 2 * HA : 0);
         end
      end
   endtask

   task automatic test_checker();
      int px[4] = '{0, 32, 32, 50};
      int py[4] = '{0, 0, 32, 10};
`ifdef VGA_CHECKER_EN
      logic ec[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
      logic ec[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
      bit ok;
      for (int i = 0; i < 4; i++) begin
         goto_pixel(px[i], py[i], ok);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL color_reach(%0d,%0d) got=timeout expected=reached", px[i], py[i]);
         end else if (color_out !== ec[i]) begin
            errors++;
            $display("FAIL color(%0d,%0d) got=%b expected=%b", px[i], py[i], color_out, ec[i]);
         end
      end
   endtask

   task automatic test_wrap();
      bit ok;
      logic [23:0] exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
      goto_pixel(HT - 1, VT - 1, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wrap_reach got=timeout expected=reached");
      end
      step();
      step();
      checks++;
      if (outs() !== exp_v) begin
         errors++;
         $display("FAIL wrap_to_origin got=%h expected=%h", outs(), exp_v);
      end
   endtask

   task automatic test_mid_reset();
      bit ok;
      int first_fall = -1;
      logic prev = 1'b1;
      goto_pixel(30, 20, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midreset_reach got=timeout expected=reached");
      end
      #2 rst_n = 1'b0;
      k = 0;
      #1;
      checks++;
      if (outs() !== RST_VEC) begin
         errors++;
         $display("FAIL midreset_async got=%h expected=%h", outs(), RST_VEC);
      end
      @(negedge clk);
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4 * HT; i++) begin
         step();
         checks++;
         if (outs() !== model(k)) begin
            errors++;
            $display("FAIL midreset_cycle k=%0d got=%h expected=%h", k, outs(), model(k));
         end
         if (prev && !hsync && first_fall < 0) first_fall = k;
         prev = hsync;
      end
      checks++;
      if (first_fall != 2 * (HA + HFP) + 1) begin
         errors++;
         $display("FAIL midreset_hsync_fall got=%0d expected=%0d", first_fall, 2 * (HA + HFP) + 1);
      end
   endtask

   task automatic test_random_reset();
      int n, off, hold;
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(3000, 20);
         for (int i = 0; i < n; i++) begin
            step();
            checks++;
            if (outs() !== model(k)) begin
               errors++;
               $display("FAIL rand_cycle r=%0d k=%0d got=%h expected=%h", r, k, outs(), model(k));
            end
         end
         off = $urandom_range(3, 1);
         #(off) rst_n = 1'b0;
         k = 0;
         #1;
         checks++;
         if (outs() !== RST_VEC) begin
            errors++;
            $display("FAIL rand_reset r=%0d got=%h expected=%h", r, outs(), RST_VEC);
         end
         @(negedge clk);
         hold = $urandom_range(2, 0);
         for (int i = 0; i < hold; i++) step();
         rst_n = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_line();
      test_frame();
      test_checker();
      test_wrap();
      test_mid_reset();
      test_random_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
